// File: rtl/prism_sit_pkg.sv
// Shared definitions for the PRISM State Information Table: debug register
// offsets, loader FSM states and an elaboration-time clog2 helper.
package prism_sit_pkg;

  localparam logic [5:0] SIT_CTRL   = 6'h00;
  localparam logic [5:0] SIT_FILL   = 6'h04;
  localparam logic [5:0] SIT_RDSEL  = 6'h08;
  localparam logic [5:0] SIT_STATUS = 6'h0C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_COMMIT,
    ST_SETTLE
  } sit_state_e;

  function automatic int sit_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prism_sit_loader.sv
// Word-serial fill/commit sequencer for the SIT: stages debug words, commits
// a full entry at ptr, then optionally advances ptr. Tracks sticky overflow.
module prism_sit_loader
  import prism_sit_pkg::*;
#(
  parameter int WIDTH  = 80,
  parameter int DEPTH  = 4,
  parameter int A_BITS = 2,
  parameter int NWORDS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_wr,
  input  logic              fill_wr,
  input  logic              status_wr,
  input  logic [31:0]       wdata,
  output logic [A_BITS-1:0] ptr,
  output logic              ainc,
  output logic              busy,
  output logic              filling,
  output logic              ovf,
  output logic [DEPTH-1:0]  ent_we,
  output logic [WIDTH-1:0]  ent_wdata
);

  sit_state_e               state_q, state_d;
  logic [A_BITS-1:0]        ptr_q, ptr_d;
  logic                     ainc_q, ainc_d;
  logic [2:0]               wr_word_q, wr_word_d;
  logic                     ovf_q, ovf_d;
  logic [NWORDS*32-1:0]     stage_q, stage_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      ainc_q    <= 1'b0;
      wr_word_q <= '0;
      ovf_q     <= 1'b0;
      stage_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ainc_q    <= ainc_d;
      wr_word_q <= wr_word_d;
      ovf_q     <= ovf_d;
      stage_q   <= stage_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ainc_d    = ainc_q;
    wr_word_d = wr_word_q;
    ovf_d     = ovf_q;
    stage_d   = stage_q;
    busy      = (state_q == ST_COMMIT) || (state_q == ST_SETTLE);
    filling   = (state_q == ST_FILL);

    if (status_wr && wdata[1]) ovf_d = 1'b0;
    // Accesses that would disturb an in-flight commit are lost, so flag them.
    if (busy && (ctrl_wr || fill_wr)) ovf_d = 1'b1;

    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (ctrl_wr) begin
          ptr_d     = wdata[A_BITS-1:0];
          ainc_d    = wdata[8];
          wr_word_d = '0;
          state_d   = ST_IDLE;
        end else if (fill_wr) begin
          stage_d[int'(wr_word_q)*32 +: 32] = wdata;
          if (wr_word_q == 3'(NWORDS - 1)) begin
            wr_word_d = '0;
            state_d   = ST_COMMIT;
          end else begin
            wr_word_d = wr_word_q + 3'd1;
            state_d   = ST_FILL;
          end
        end
      end
      ST_COMMIT: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (ainc_q) ptr_d = (ptr_q == A_BITS'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ent_we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_we[i] = (state_q == ST_COMMIT) && (ptr_q == A_BITS'(i));
    end
  end

  assign ent_wdata = stage_q[WIDTH-1:0];
  assign ptr       = ptr_q;
  assign ainc      = ainc_q;
  assign ovf       = ovf_q;

endmodule

// File: rtl/prism_sit_bank.sv
// PRISM State Information Table: entry storage, independent read ports for the
// state-machine core, and debug-bus register decode/readback.
module prism_sit_bank
  import prism_sit_pkg::*;
#(
  parameter int WIDTH   = 80,
  parameter int DEPTH   = 4,
  parameter int NPORTS  = 2,
  parameter int REG_OUT = 0,
  localparam int A_BITS = sit_clog2(DEPTH),
  localparam int NWORDS = (WIDTH + 31) / 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               debug_addr,
  input  logic                     debug_wr,
  input  logic [31:0]              debug_wdata,
  output logic [31:0]              debug_rdata,
  input  logic [NPORTS*A_BITS-1:0] raddr,
  output logic [NPORTS*WIDTH-1:0]  rdata,
  output logic                     busy
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [2:0]        rd_word_q, rd_word_d;
  logic [A_BITS-1:0] ptr;
  logic              ainc, filling, ovf;
  logic [DEPTH-1:0]  ent_we;
  logic [WIDTH-1:0]  ent_wdata;
  logic [255:0]      sel_words;

  prism_sit_loader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .A_BITS(A_BITS),
    .NWORDS(NWORDS)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .ctrl_wr  (debug_wr && (debug_addr == SIT_CTRL)),
    .fill_wr  (debug_wr && (debug_addr == SIT_FILL)),
    .status_wr(debug_wr && (debug_addr == SIT_STATUS)),
    .wdata    (debug_wdata),
    .ptr      (ptr),
    .ainc     (ainc),
    .busy     (busy),
    .filling  (filling),
    .ovf      (ovf),
    .ent_we   (ent_we),
    .ent_wdata(ent_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_word_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_word_q <= rd_word_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = ent_we[i] ? ent_wdata : mem_q[i];
    end
    rd_word_d = (debug_wr && (debug_addr == SIT_RDSEL)) ? debug_wdata[2:0] : rd_word_q;
  end

  // Entry at ptr padded to 8 words so every rd_word value selects in range.
  always_comb begin
    sel_words = '0;
    if (int'(ptr) < DEPTH) sel_words[WIDTH-1:0] = mem_q[ptr];
  end

  always_comb begin
    debug_rdata = '0;
    case (debug_addr)
      SIT_CTRL:   debug_rdata = {busy, 23'b0, ainc, 7'(ptr)};
      SIT_RDSEL:  if (int'(rd_word_q) < NWORDS) debug_rdata = sel_words[int'(rd_word_q)*32 +: 32];
      SIT_STATUS: debug_rdata = {29'b0, filling, ovf, busy};
      default:    debug_rdata = '0;
    endcase
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [A_BITS-1:0] ra;
    logic [WIDTH-1:0]  rd_c;

    assign ra = raddr[p*A_BITS +: A_BITS];

    always_comb begin
      rd_c = '0;
      if (int'(ra) < DEPTH) rd_c = mem_q[ra];
    end

    if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] rd_q, rd_d;
      assign rd_d = rd_c;
      always_ff @(posedge clk) begin
        if (rst) rd_q <= '0;
        else     rd_q <= rd_d;
      end
      assign rdata[p*WIDTH +: WIDTH] = rd_q;
    end else begin : g_comb
      assign rdata[p*WIDTH +: WIDTH] = rd_c;
    end
  end

endmodule
